// File: rtl/lms_fir_seq.sv
// Time-multiplexed LMS adaptive FIR: one shared multiplier walks the taps per sample,
// emits a saturated output/error, then optionally adapts every coefficient.
module lms_fir_seq #(
    parameter int unsigned W        = 16,
    parameter int unsigned TAPS     = 8,
    parameter int unsigned FRAC     = 12,
    parameter int unsigned MU_SHIFT = 10,
    parameter int unsigned AW       = $clog2(TAPS)
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] d_in,
    input  logic                adapt_en,
    input  logic                coef_wr,
    input  logic [AW-1:0]       coef_addr,
    input  logic signed [W-1:0] coef_data,
    output logic                out_valid,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] err_out,
    output logic                sat_flag
);

    localparam int unsigned P_W   = 2 * W;
    localparam int unsigned ACC_W = 2 * W + AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_ERR  = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0]     x_q [TAPS];
    logic signed [W-1:0]     k_q [TAPS];
    logic signed [W-1:0]     d_q;
    logic                    adapt_q;
    logic signed [ACC_W-1:0] acc;
    logic [AW-1:0]           idx;

    logic accept_c, mac_en_c, err_en_c, upd_en_c, coef_we_c, last_c;

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = S_MAC;
            S_MAC:  if (last_c)   state_nxt = S_ERR;
            S_ERR:  state_nxt = adapt_q ? S_UPD : S_IDLE;
            S_UPD:  if (last_c)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode: in_ready depends on state only
    always_comb begin
        in_ready  = 1'b0;
        accept_c  = 1'b0;
        mac_en_c  = 1'b0;
        err_en_c  = 1'b0;
        upd_en_c  = 1'b0;
        coef_we_c = 1'b0;
        last_c    = (idx == LAST_IDX);
        case (state)
            S_IDLE: begin
                in_ready  = 1'b1;
                accept_c  = in_valid;
                coef_we_c = coef_wr && (32'(coef_addr) < TAPS);
            end
            S_MAC:   mac_en_c = 1'b1;
            S_ERR:   err_en_c = 1'b1;
            S_UPD:   upd_en_c = 1'b1;
            default: ;
        endcase
    end

    // Shared operand select and arithmetic
    logic signed [W-1:0]     x_sel, k_sel;
    logic signed [P_W-1:0]   mac_prod;
    logic signed [ACC_W-1:0] acc_sh;
    logic                    y_ovf;
    logic signed [W-1:0]     y_sat;
    logic signed [W:0]       diff;
    logic                    e_ovf;
    logic signed [W-1:0]     e_sat;
    logic signed [P_W-1:0]   upd_prod, upd_sh;
    logic [P_W:0]            upd_sum;
    logic                    upd_ovf;
    logic signed [W-1:0]     k_new;

    assign x_sel    = x_q[idx];
    assign k_sel    = k_q[idx];
    assign mac_prod = P_W'(k_sel) * P_W'(x_sel);

    assign acc_sh = acc >>> FRAC;
    assign y_ovf  = !((&acc_sh[ACC_W-1:W-1]) || !(|acc_sh[ACC_W-1:W-1]));
    assign y_sat  = y_ovf ? (acc_sh[ACC_W-1] ? S_MIN : S_MAX) : acc_sh[W-1:0];

    // Error in W+1 bits so d - y never wraps before clamping
    assign diff  = {d_q[W-1], d_q} - {y_sat[W-1], y_sat};
    assign e_ovf = diff[W] ^ diff[W-1];
    assign e_sat = e_ovf ? (diff[W] ? S_MIN : S_MAX) : diff[W-1:0];

    // Update uses the registered error held in err_out
    assign upd_prod = P_W'(err_out) * P_W'(x_sel);
    assign upd_sh   = upd_prod >>> MU_SHIFT;
    assign upd_sum  = {upd_sh[P_W-1], upd_sh} + {{(W+1){k_sel[W-1]}}, k_sel};
    assign upd_ovf  = !((&upd_sum[P_W:W-1]) || !(|upd_sum[P_W:W-1]));
    assign k_new    = upd_ovf ? (upd_sum[P_W] ? S_MIN : S_MAX) : upd_sum[W-1:0];

    // Datapath registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                x_q[i] <= '0;
                k_q[i] <= '0;
            end
            d_q       <= '0;
            adapt_q   <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            y_out     <= '0;
            err_out   <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (coef_we_c) k_q[coef_addr] <= coef_data;
            if (accept_c) begin
                for (int i = int'(TAPS) - 1; i > 0; i--) x_q[i] <= x_q[i-1];
                x_q[0]  <= x_in;
                d_q     <= d_in;
                adapt_q <= adapt_en;
                acc     <= '0;
                idx     <= '0;
            end
            if (mac_en_c) begin
                acc <= acc + {{AW{mac_prod[P_W-1]}}, mac_prod};
                idx <= last_c ? '0 : idx + AW'(1);
            end
            if (err_en_c) begin
                y_out     <= y_sat;
                err_out   <= e_sat;
                sat_flag  <= y_ovf | e_ovf;
                out_valid <= 1'b1;
                idx       <= '0;
            end
            if (upd_en_c) begin
                k_q[idx] <= k_new;
                idx      <= last_c ? '0 : idx + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lms_fir_seq.sv
// Randomised scoreboard bench for lms_fir_seq (TAPS=4, FRAC=0, MU_SHIFT=0).
module tb_lms_fir_seq;

    localparam int W = 16;
    localparam int TAPS = 4;
    localparam int FRAC = 0;
    localparam int MU = 0;
    localparam int AW = 2;

    logic                clk = 1'b0;
    logic                clr_n = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] x_in = '0;
    logic signed [W-1:0] d_in = '0;
    logic                adapt_en = 1'b0;
    logic                coef_wr = 1'b0;
    logic [AW-1:0]       coef_addr = '0;
    logic signed [W-1:0] coef_data = '0;
    logic                out_valid;
    logic signed [W-1:0] y_out;
    logic signed [W-1:0] err_out;
    logic                sat_flag;

    lms_fir_seq #(.W(W), .TAPS(TAPS), .FRAC(FRAC), .MU_SHIFT(MU), .AW(AW)) dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .d_in(d_in), .adapt_en(adapt_en), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid),
        .y_out(y_out), .err_out(err_out), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int y;
        int e;
        bit s;
        int acc_cyc;
    } exp_t;

    exp_t q[$];
    int   mk[TAPS];
    int   mx[TAPS];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_acc = -1;
    bit   chk_rate = 1'b0;
    int   want_rate = 0;

    function automatic int sat(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: direct sum-of-products, saturation and LMS update from the filter equations
    task automatic model_accept(input int xv, input int dv, input bit ad, input int acyc);
        longint sum;
        longint ysh;
        exp_t   it;
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = xv;
        sum = 0;
        for (int i = 0; i < TAPS; i++) sum += longint'(mk[i]) * longint'(mx[i]);
        ysh = sum >>> FRAC;
        it.y = sat(ysh);
        it.e = sat(longint'(dv) - longint'(it.y));
        it.s = (longint'(it.y) != ysh) || (longint'(it.e) != longint'(dv) - longint'(it.y));
        it.acc_cyc = acyc;
        q.push_back(it);
        if (ad)
            for (int i = 0; i < TAPS; i++)
                mk[i] = sat(longint'(mk[i]) + ((longint'(it.e) * longint'(mx[i])) >>> MU));
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mk[i] = 0;
            mx[i] = 0;
        end
    endtask

    // Offer one sample; optional coefficient write in the accept cycle
    task automatic send(input int xv, input int dv, input bit ad,
                        input bit wr = 1'b0, input int wa = 0, input int wd = 0);
        int n;
        int acyc;
        @(negedge clk);
        x_in = 16'(xv);
        d_in = 16'(dv);
        adapt_en = ad;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (wr) begin
            coef_wr = 1'b1;
            coef_addr = 2'(wa);
            coef_data = 16'(wd);
        end
        acyc = cyc;
        if (chk_rate && last_acc >= 0) check("accept_interval", acyc - last_acc, want_rate);
        last_acc = acyc;
        @(posedge clk);
        if (wr) mk[wa] = wd;
        model_accept(xv, dv, ad, acyc);
        if (wr) begin
            @(negedge clk);
            coef_wr = 1'b0;
        end
    endtask

    task automatic write_coef(input int a, input int d);
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        coef_wr = 1'b1;
        coef_addr = 2'(a);
        coef_data = 16'(d);
        @(posedge clk);
        mk[a] = d;
        @(negedge clk);
        coef_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    // Monitor: every out_valid pulse pops one expected result
    always @(negedge clk) begin
        if (clr_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t it;
                it = q.pop_front();
                check("y_out", longint'(y_out), it.y);
                check("err_out", longint'(err_out), it.e);
                check("sat_flag", sat_flag, it.s);
                check("latency", cyc - it.acc_cyc, TAPS + 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int xv;
        int dv;
        model_reset();

        // Reset
        #1 clr_n = 1'b0;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_out", longint'(y_out), 0);
        check("rst_err_out", longint'(err_out), 0);
        send(7, 0, 1'b0);
        idle(2);
        drain();

        // Impulse through k={1,2,3,4}
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        send(1, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        idle(2);
        drain();

        // Adaptation from zero coefficients
        for (int i = 0; i < TAPS; i++) write_coef(i, 0);
        send(1, 5, 1'b1);
        send(0, 0, 1'b1);
        send(1, 5, 1'b1);
        idle(2);
        drain();

        // Saturation of both y and err
        for (int i = 1; i < TAPS; i++) write_coef(i, 0);
        write_coef(0, 32767);
        send(2, -32768, 1'b0);
        idle(2);
        drain();

        // Coefficient write in the accept cycle is used by that sample
        send(3, 10, 1'b0, 1'b1, 0, 2);
        idle(2);
        drain();

        // Back-to-back throughput
        chk_rate = 1'b1;
        want_rate = 2 * TAPS + 2;
        last_acc = -1;
        for (int i = 0; i < 5; i++) send(i + 1, 3, 1'b1);
        idle(2);
        drain();
        want_rate = TAPS + 2;
        last_acc = -1;
        for (int i = 0; i < 5; i++) send(i - 2, -1, 1'b0);
        idle(2);
        drain();
        chk_rate = 1'b0;

        // Coefficient write during MAC is ignored
        for (int i = 0; i < TAPS; i++) write_coef(i, 4 - i);
        send(1, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        coef_wr = 1'b1;
        coef_addr = 2'(1);
        coef_data = 16'(99);
        @(negedge clk);
        coef_wr = 1'b0;
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        idle(2);
        drain();

        // Reset during the update pass
        send(1, 5, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 clr_n = 1'b0;
        check("pending_before_reset", q.size(), 0);
        q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_out_valid_after_reset", seen, 0);
        check("ready_after_reset", in_ready, 1);
        send(1, 0, 1'b0);
        idle(2);
        drain();

        // Randomised traffic
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 7) == 0)
                write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 63)) - 32);
            if ($urandom_range(0, 9) == 0) begin
                xv = int'($signed(16'($urandom)));
                dv = int'($signed(16'($urandom)));
            end else begin
                xv = int'($urandom_range(0, 127)) - 64;
                dv = int'($urandom_range(0, 511)) - 256;
            end
            send(xv, dv, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 5)));
        end
        idle(2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
